// File: rtl/mem_trace_recorder.sv
// rtl/mem_trace_recorder.sv - multi-channel memory-access trace recorder with FWFT trace FIFO
// Each channel parks one {addr, ts} in a pending slot; a round-robin arbiter moves slots into the FIFO.
module mem_trace_recorder #(
  parameter int NUM_CH = 2,
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 16,
  parameter int TS_W   = 16,
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int ENT_W = CH_W + TS_W + ADDR_W
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     enable_i,
  input  logic                     clear_i,
  input  logic [NUM_CH-1:0]        ch_valid_i,
  input  logic [NUM_CH*ADDR_W-1:0] ch_addr_i,
  output logic                     rd_valid_o,
  input  logic                     rd_ready_i,
  output logic [ENT_W-1:0]         rd_data_o,
  output logic [PTR_W:0]           level_o,
  output logic [TS_W-1:0]          drop_cnt_o
);

  localparam int               DROP_W     = TS_W + CH_W + 1;
  localparam logic [CH_W:0]    NUM_CH_EXT = (CH_W+1)'(NUM_CH);
  localparam logic [CH_W-1:0]  LAST_CH    = CH_W'(NUM_CH - 1);
  localparam logic [PTR_W:0]   DEPTH_EXT  = (PTR_W+1)'(DEPTH);
  localparam logic [DROP_W-1:0] DROP_MAX  = {{(CH_W+1){1'b0}}, {TS_W{1'b1}}};

  logic [TS_W-1:0]   ts;
  logic [NUM_CH-1:0] slot_full;
  logic [ADDR_W-1:0] slot_addr [NUM_CH];
  logic [TS_W-1:0]   slot_ts   [NUM_CH];
  logic [CH_W-1:0]   rr;
  logic [ENT_W-1:0]  mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W:0]    count;
  logic [TS_W-1:0]   drop_cnt;

  logic              pop;
  logic              push;
  logic              grant_valid;
  logic [CH_W-1:0]   grant_idx;
  logic [CH_W:0]     cand;
  logic [CH_W-1:0]   rr_next;
  logic [ENT_W-1:0]  push_data;
  logic [NUM_CH-1:0] slot_load;
  logic [CH_W:0]     ndrop;
  logic [DROP_W-1:0] drop_sum;
  logic [TS_W-1:0]   drop_next;

  assign rd_valid_o = (count != '0);
  assign pop        = rd_valid_o && rd_ready_i;
  assign rd_data_o  = rd_valid_o ? mem[rd_ptr] : '0;
  assign level_o    = count;
  assign drop_cnt_o = drop_cnt;

  // Round-robin search over occupied slots, starting at rr and wrapping.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      cand = {1'b0, rr} + (CH_W+1)'(i);
      if (cand >= NUM_CH_EXT) begin
        cand = cand - NUM_CH_EXT;
      end
      if (!grant_valid && slot_full[cand[CH_W-1:0]]) begin
        grant_valid = 1'b1;
        grant_idx   = cand[CH_W-1:0];
      end
    end
  end

  assign push      = grant_valid && ((count != DEPTH_EXT) || pop);
  assign rr_next   = (grant_idx == LAST_CH) ? '0 : grant_idx + CH_W'(1);
  assign push_data = {grant_idx, slot_ts[grant_idx], slot_addr[grant_idx]};

  // A slot freed by this cycle's grant can take a new access at the same edge.
  always_comb begin
    slot_load = '0;
    ndrop     = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (enable_i && ch_valid_i[c]) begin
        if (!slot_full[c] || (push && (grant_idx == CH_W'(c)))) begin
          slot_load[c] = 1'b1;
        end else begin
          ndrop = ndrop + (CH_W+1)'(1);
        end
      end
    end
    drop_sum  = {{(CH_W+1){1'b0}}, drop_cnt} + {{TS_W{1'b0}}, ndrop};
    drop_next = (drop_sum > DROP_MAX) ? {TS_W{1'b1}} : drop_sum[TS_W-1:0];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ts        <= '0;
      slot_full <= '0;
      rr        <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      drop_cnt  <= '0;
    end else if (clear_i) begin
      ts        <= '0;
      slot_full <= '0;
      rr        <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      drop_cnt  <= '0;
    end else begin
      ts       <= ts + TS_W'(1);
      drop_cnt <= drop_next;
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
        rr     <= rr_next;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
      for (int c = 0; c < NUM_CH; c++) begin
        if (slot_load[c]) begin
          slot_full[c] <= 1'b1;
        end else if (push && (grant_idx == CH_W'(c))) begin
          slot_full[c] <= 1'b0;
        end
      end
    end
  end

  // Slot payload is only meaningful while slot_full is set, so it needs no flush.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int c = 0; c < NUM_CH; c++) begin
        slot_addr[c] <= '0;
        slot_ts[c]   <= '0;
      end
    end else if (!clear_i) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (slot_load[c]) begin
          slot_addr[c] <= ch_addr_i[c*ADDR_W +: ADDR_W];
          slot_ts[c]   <= ts;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (push && !clear_i) begin
      mem[wr_ptr] <= push_data;
    end
  end

endmodule

// File: tb/tb_mem_trace_recorder.sv
// tb/tb_mem_trace_recorder.sv - self-checking bench for mem_trace_recorder
// Directed vector table, hand sequences for stall/saturation/clear/reset, and random traffic vs a queue model.
module tb_mem_trace_recorder;

  localparam int NUM_CH = 2;
  localparam int ADDR_W = 32;
  localparam int DEPTH  = 16;
  localparam int TS_W   = 16;
  localparam int CH_W   = 1;
  localparam int PTR_W  = 4;
  localparam int ENT_W  = CH_W + TS_W + ADDR_W;
  localparam int TS_MOD = 65536;
  localparam int DROP_SAT = 65535;

  logic                     clk;
  logic                     rst;
  logic                     enable;
  logic                     clear;
  logic [NUM_CH-1:0]        ch_valid;
  logic [NUM_CH*ADDR_W-1:0] ch_addr;
  logic                     rd_valid;
  logic                     rd_ready;
  logic [ENT_W-1:0]         rd_data;
  logic [PTR_W:0]           level;
  logic [TS_W-1:0]          drop_cnt;

  mem_trace_recorder #(
    .NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .TS_W(TS_W)
  ) dut (
    .clk_i(clk), .rst_i(rst), .enable_i(enable), .clear_i(clear),
    .ch_valid_i(ch_valid), .ch_addr_i(ch_addr),
    .rd_valid_o(rd_valid), .rd_ready_i(rd_ready), .rd_data_o(rd_data),
    .level_o(level), .drop_cnt_o(drop_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [ENT_W-1:0] mk(input logic [CH_W-1:0] ch, input logic [TS_W-1:0] t,
                                          input logic [ADDR_W-1:0] a);
    return {ch, t, a};
  endfunction

  // Reference model: FIFO as a queue, slots as arrays, counters as plain integers.
  logic [ENT_W-1:0]  mq[$];
  logic              m_sf [NUM_CH];
  logic [ADDR_W-1:0] m_sa [NUM_CH];
  int                m_st [NUM_CH];
  int                m_rr;
  int                m_ts;
  int                m_drop;

  task automatic model_reset();
    mq.delete();
    for (int c = 0; c < NUM_CH; c++) begin
      m_sf[c] = 1'b0;
      m_sa[c] = '0;
      m_st[c] = 0;
    end
    m_rr = 0;
    m_ts = 0;
    m_drop = 0;
  endtask

  task automatic model_step(input logic en, input logic clr, input logic [NUM_CH-1:0] v,
                            input logic [NUM_CH*ADDR_W-1:0] addrs, input logic rdy);
    bit pop_now;
    bit push_now;
    int g;
    int nd;
    if (clr) begin
      model_reset();
      return;
    end
    pop_now = (mq.size() > 0) && rdy;
    g = -1;
    for (int k = 0; k < NUM_CH; k++) begin
      int c = (m_rr + k) % NUM_CH;
      if (g < 0 && m_sf[c]) g = c;
    end
    push_now = (g >= 0) && ((mq.size() < DEPTH) || pop_now);
    if (pop_now) void'(mq.pop_front());
    if (push_now) begin
      mq.push_back(mk(CH_W'(g), TS_W'(m_st[g]), m_sa[g]));
      m_sf[g] = 1'b0;
      m_rr = (g + 1) % NUM_CH;
    end
    nd = 0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (en && v[c]) begin
        if (!m_sf[c]) begin
          m_sf[c] = 1'b1;
          m_sa[c] = addrs[c*ADDR_W +: ADDR_W];
          m_st[c] = m_ts;
        end else begin
          nd++;
        end
      end
    end
    m_drop = (m_drop + nd > DROP_SAT) ? DROP_SAT : m_drop + nd;
    m_ts = (m_ts + 1) % TS_MOD;
  endtask

  logic             s_valid;
  logic [ENT_W-1:0] s_data;
  logic [PTR_W:0]   s_level;
  logic [TS_W-1:0]  s_drop;
  bit               rec = 0;
  logic [ENT_W-1:0] popped[$];

  // Drive one cycle: inputs now, sample and compare at negedge, advance model, return after posedge.
  task automatic step(input logic en, input logic clr, input logic [NUM_CH-1:0] v,
                      input logic [NUM_CH*ADDR_W-1:0] addrs, input logic rdy);
    enable = en; clear = clr; ch_valid = v; ch_addr = addrs; rd_ready = rdy;
    @(negedge clk);
    s_valid = rd_valid; s_data = rd_data; s_level = level; s_drop = drop_cnt;
    chk("model_valid", 64'(s_valid), 64'(mq.size() != 0));
    chk("model_data", 64'(s_data), (mq.size() != 0) ? 64'(mq[0]) : 64'd0);
    chk("model_level", 64'(s_level), 64'(mq.size()));
    chk("model_drop", 64'(s_drop), 64'(m_drop));
    if (rec && rd_valid && rdy) popped.push_back(rd_data);
    model_step(en, clr, v, addrs, rdy);
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic             en;
    logic             clr;
    logic [1:0]       v;
    logic [31:0]      a0;
    logic [31:0]      a1;
    logic             rdy;
    logic             e_valid;
    logic [ENT_W-1:0] e_data;
    int               e_level;
    int               e_drop;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic en, input logic clr, input logic [1:0] v, input logic [31:0] a0,
                     input logic [31:0] a1, input logic rdy, input logic ev,
                     input logic [ENT_W-1:0] ed, input int el);
    vec_t r;
    r.en = en; r.clr = clr; r.v = v; r.a0 = a0; r.a1 = a1; r.rdy = rdy;
    r.e_valid = ev; r.e_data = ed; r.e_level = el; r.e_drop = 0;
    tbl.push_back(r);
  endtask

  task automatic fill_stall(input int n);
    for (int k = 0; k < n; k++) step(1'b1, 1'b0, 2'b01, {32'h0, 32'h1000 + 32'(k)}, 1'b0);
  endtask

  initial begin
    bit found;
    rst = 1'b1; enable = 1'b0; clear = 1'b0; ch_valid = '0; ch_addr = '0; rd_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Row i is the cycle whose timestamp is i until the clear in row 9.
    for (int i = 0; i < 5; i++) add(1, 0, 2'b00, 0, 0, 0, 0, '0, 0);
    add(1, 0, 2'b01, 32'h40, 0, 0, 0, '0, 0);
    add(1, 0, 2'b00, 0, 0, 0, 0, '0, 0);
    add(1, 0, 2'b00, 0, 0, 0, 1, mk(0, 5, 32'h40), 1);
    add(1, 0, 2'b00, 0, 0, 1, 1, mk(0, 5, 32'h40), 1);
    add(1, 1, 2'b00, 0, 0, 0, 0, '0, 0);
    add(1, 0, 2'b11, 32'h100, 32'h200, 0, 0, '0, 0);
    add(1, 0, 2'b00, 0, 0, 0, 0, '0, 0);
    add(1, 0, 2'b00, 0, 0, 0, 1, mk(0, 0, 32'h100), 1);
    add(1, 0, 2'b00, 0, 0, 1, 1, mk(0, 0, 32'h100), 2);
    add(1, 0, 2'b00, 0, 0, 1, 1, mk(1, 0, 32'h200), 1);
    add(1, 0, 2'b01, 32'h300, 0, 0, 0, '0, 0);
    add(1, 0, 2'b00, 0, 0, 0, 0, '0, 0);
    add(1, 0, 2'b11, 32'h400, 32'h500, 0, 1, mk(0, 5, 32'h300), 1);
    add(1, 0, 2'b00, 0, 0, 0, 1, mk(0, 5, 32'h300), 1);
    add(1, 0, 2'b00, 0, 0, 0, 1, mk(0, 5, 32'h300), 2);
    add(1, 0, 2'b00, 0, 0, 1, 1, mk(0, 5, 32'h300), 3);
    add(1, 0, 2'b00, 0, 0, 1, 1, mk(1, 7, 32'h500), 2);
    add(1, 0, 2'b00, 0, 0, 1, 1, mk(0, 7, 32'h400), 1);
    add(1, 0, 2'b00, 0, 0, 0, 0, '0, 0);
    add(1, 0, 2'b01, 32'h600, 0, 0, 0, '0, 0);
    add(1, 0, 2'b01, 32'h700, 0, 0, 0, '0, 0);
    add(1, 0, 2'b01, 32'h800, 0, 0, 1, mk(0, 14, 32'h600), 1);
    add(1, 0, 2'b00, 0, 0, 0, 1, mk(0, 14, 32'h600), 2);
    add(1, 1, 2'b00, 0, 0, 0, 1, mk(0, 14, 32'h600), 3);
    add(0, 0, 2'b11, 32'h900, 32'hA00, 0, 0, '0, 0);
    add(1, 0, 2'b00, 0, 0, 0, 0, '0, 0);
    add(1, 0, 2'b00, 0, 0, 0, 0, '0, 0);

    foreach (tbl[i]) begin
      step(tbl[i].en, tbl[i].clr, tbl[i].v, {tbl[i].a1, tbl[i].a0}, tbl[i].rdy);
      chk($sformatf("tbl%0d_valid", i), 64'(s_valid), 64'(tbl[i].e_valid));
      chk($sformatf("tbl%0d_data", i), 64'(s_data), 64'(tbl[i].e_data));
      chk($sformatf("tbl%0d_level", i), 64'(s_level), 64'(tbl[i].e_level));
      chk($sformatf("tbl%0d_drop", i), 64'(s_drop), 64'(tbl[i].e_drop));
    end

    // Stall: 16 entries fill, one waits in the slot, the last three accesses drop.
    step(1, 1, 2'b00, '0, 0);
    fill_stall(20);
    step(1, 0, 2'b00, '0, 1);
    chk("stall_level", 64'(s_level), 64'd16);
    chk("stall_drop", 64'(s_drop), 64'd3);
    step(1, 0, 2'b00, '0, 0);
    chk("popush_level", 64'(s_level), 64'd16);
    for (int j = 1; j <= 16; j++) begin
      step(1, 0, 2'b00, '0, 1);
      chk($sformatf("drain_%0d", j), 64'(s_data), 64'(mk(0, TS_W'(j), 32'h1000 + 32'(j))));
    end
    step(1, 0, 2'b00, '0, 0);
    chk("drained_level", 64'(s_level), 64'd0);

    // Clear with full FIFO and a same-cycle handshake.
    step(1, 1, 2'b00, '0, 0);
    fill_stall(20);
    step(1, 1, 2'b11, {32'hDEAD, 32'hBEEF}, 1);
    chk("preclr_level", 64'(s_level), 64'd16);
    step(1, 0, 2'b00, '0, 0);
    chk("clr_level", 64'(s_level), 64'd0);
    chk("clr_valid", 64'(s_valid), 64'd0);
    chk("clr_drop", 64'(s_drop), 64'd0);
    chk("clr_data", 64'(s_data), 64'd0);

    // Async reset in the middle of a cycle must clear outputs before the next edge.
    fill_stall(20);
    chk("prerst_drop", 64'(s_drop), 64'd2);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_valid", 64'(rd_valid), 64'd0);
    chk("rst_data", 64'(rd_data), 64'd0);
    chk("rst_level", 64'(level), 64'd0);
    chk("rst_drop", 64'(drop_cnt), 64'd0);
    model_reset();
    enable = 0; ch_valid = '0; rd_ready = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;

    for (int k = 0; k < 3000; k++) begin
      logic rdy;
      if (k < 1000) rdy = ($urandom_range(0, 3) != 0);
      else if (k < 2000) rdy = ($urandom_range(0, 3) == 0);
      else rdy = $urandom_range(0, 1) != 0;
      step($urandom_range(0, 9) != 0, $urandom_range(0, 199) == 0, NUM_CH'($urandom_range(0, 3)),
           {$urandom, $urandom}, rdy);
    end

    // Long stall on both channels saturates the drop counter and walks ts up to 0xFFF0.
    step(1, 1, 2'b00, '0, 0);
    for (int k = 0; k < 65520; k++) step(1, 0, 2'b11, {32'hAAAA, 32'h5555}, 0);
    step(1, 0, 2'b11, {32'hAAAA, 32'h5555}, 0);
    chk("sat_drop", 64'(s_drop), 64'hFFFF);
    chk("sat_level", 64'(s_level), 64'd16);
    rec = 1;
    for (int k = 0; k < 60; k++) step(1, 0, 2'b01, {32'h0, 32'h7000 + 32'(k)}, 1);
    rec = 0;
    chk("sat_hold", 64'(s_drop), 64'hFFFF);
    found = 0;
    for (int i = 0; i + 1 < popped.size(); i++) begin
      if (popped[i][ENT_W-1] == 1'b0 && popped[i+1][ENT_W-1] == 1'b0 &&
          popped[i][ADDR_W +: TS_W] == 16'hFFFF && popped[i+1][ADDR_W +: TS_W] == 16'h0000)
        found = 1;
    end
    chk("ts_wrap", 64'(found), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
